// File: rtl/bandit_agent.sv
// ============================================================================
// bandit_agent : greedy multi-armed bandit with a sequential argmax scan
//                and a shift-based action-value update.
//                Optional epsilon exploration: define BANDIT_EXPLORE_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bandit_agent #(
  parameter int          ACTIONS      = 256,
  parameter int          ACTION_WIDTH = $clog2(ACTIONS),
  parameter int          REWARD_WIDTH = 8,
  parameter int          VALUE_WIDTH  = 8,
  parameter int          ALPHA_SHIFT  = 3,
  parameter int          INIT_VALUE   = 0,
  parameter int          EPSILON      = 8,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reward_valid,
  input  logic [REWARD_WIDTH-1:0] reward_data,
  output logic                    reward_ready,
  output logic                    action_valid,
  output logic [ACTION_WIDTH-1:0] action_data,
  input  logic                    action_ready
);

  localparam int c_cw = VALUE_WIDTH + 2;

  localparam logic [1:0] c_select = 2'd0;
  localparam logic [1:0] c_offer  = 2'd1;
  localparam logic [1:0] c_wait   = 2'd2;
  localparam logic [1:0] c_update = 2'd3;

  localparam logic signed [VALUE_WIDTH-1:0] c_init     = INIT_VALUE[VALUE_WIDTH-1:0];
  localparam logic [ACTION_WIDTH-1:0]       c_last_idx = ACTION_WIDTH'(ACTIONS - 1);
  localparam logic signed [c_cw-1:0]        c_vmax     = {3'b000, {(VALUE_WIDTH-1){1'b1}}};
  localparam logic signed [c_cw-1:0]        c_vmin     = {3'b111, {(VALUE_WIDTH-1){1'b0}}};

  if ((ACTIONS < 2) || ((ACTIONS & (ACTIONS - 1)) != 0) ||
      (ACTION_WIDTH != $clog2(ACTIONS)) || (VALUE_WIDTH < REWARD_WIDTH) ||
      (ALPHA_SHIFT < 0) || (ALPHA_SHIFT > VALUE_WIDTH) ||
      (EPSILON < 0) || (EPSILON > 256) || (SEED == 16'h0000)) begin : g_param_check
    $error("bandit_agent: illegal parameter combination");
  end

  logic [1:0]                     r_state;
  logic [ACTION_WIDTH-1:0]        r_scan_idx;
  logic [ACTION_WIDTH-1:0]        r_best_idx;
  logic signed [VALUE_WIDTH-1:0]  r_best_val;
  logic                           r_scan_done;
  logic signed [REWARD_WIDTH-1:0] r_reward;
  logic signed [VALUE_WIDTH-1:0]  r_q [ACTIONS];

  logic signed [VALUE_WIDTH-1:0]  w_cur;
  logic                           w_better;
  logic [ACTION_WIDTH-1:0]        w_pick;
  logic signed [c_cw-1:0]         w_q_ext;
  logic signed [c_cw-1:0]         w_r_ext;
  logic signed [c_cw-1:0]         w_diff;
  logic signed [c_cw-1:0]         w_step;
  logic signed [c_cw-1:0]         w_sum;
  logic signed [VALUE_WIDTH-1:0]  w_new;

  // Index 0 always seeds the running best, so a stale best from the
  // previous round never survives into a new scan.
  assign w_cur    = r_q[r_scan_idx];
  assign w_better = (r_scan_idx == '0) || (w_cur > r_best_val);

`ifdef BANDIT_EXPLORE_EN
  if (ACTION_WIDTH > 8) begin : g_explore_check
    $error("bandit_agent: exploration needs ACTION_WIDTH <= 8");
  end

  logic [15:0] r_lfsr;
  logic        w_explore;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_explore = (int'(r_lfsr[7:0]) < EPSILON);
  assign w_pick    = w_explore ? r_lfsr[8 +: ACTION_WIDTH] : r_best_idx;
`else
  assign w_pick = r_best_idx;
`endif

  // Value update in two extra bits of headroom, then clamp.
  assign w_q_ext = {{(c_cw-VALUE_WIDTH){r_q[action_data][VALUE_WIDTH-1]}}, r_q[action_data]};
  assign w_r_ext = {{(c_cw-REWARD_WIDTH){r_reward[REWARD_WIDTH-1]}}, r_reward};
  assign w_diff  = w_r_ext - w_q_ext;
  assign w_step  = w_diff >>> ALPHA_SHIFT;
  assign w_sum   = w_q_ext + w_step;

  always_comb begin
    w_new = w_sum[VALUE_WIDTH-1:0];
    if (w_sum > c_vmax) begin
      w_new = c_vmax[VALUE_WIDTH-1:0];
    end else if (w_sum < c_vmin) begin
      w_new = c_vmin[VALUE_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= c_select;
      r_scan_idx   <= '0;
      r_best_idx   <= '0;
      r_best_val   <= c_init;
      r_scan_done  <= 1'b0;
      r_reward     <= '0;
      action_valid <= 1'b0;
      action_data  <= '0;
      reward_ready <= 1'b0;
    end else begin
      case (r_state)
        c_select: begin
          if (!r_scan_done) begin
            if (w_better) begin
              r_best_idx <= r_scan_idx;
              r_best_val <= w_cur;
            end
            if (r_scan_idx == c_last_idx) begin
              r_scan_done <= 1'b1;
            end
            r_scan_idx <= r_scan_idx + 1'b1;
          end else begin
            // Extra cycle lets the final comparison settle before issuing.
            r_scan_done  <= 1'b0;
            action_data  <= w_pick;
            action_valid <= 1'b1;
            r_state      <= c_offer;
          end
        end
        c_offer: begin
          if (action_ready) begin
            action_valid <= 1'b0;
            reward_ready <= 1'b1;
            r_state      <= c_wait;
          end
        end
        c_wait: begin
          if (reward_valid) begin
            r_reward     <= reward_data;
            reward_ready <= 1'b0;
            r_state      <= c_update;
          end
        end
        default: begin
          r_state <= c_select;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ACTIONS; i++) begin
        r_q[i] <= c_init;
      end
    end else if (r_state == c_update) begin
      r_q[action_data] <= w_new;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bandit_agent.sv
// ============================================================================
// tb_bandit_agent : randomized bench with a behavioural value-table model;
//                   lane 0 uses ALPHA_SHIFT=0, lane 1 uses ALPHA_SHIFT=3.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_bandit_agent;

  localparam int NA = 4;
  localparam int AW = 2;
  localparam int RW = 8;
  localparam int VW = 8;
  localparam int VMAX = (1 << (VW - 1)) - 1;
  localparam int VMIN = -(1 << (VW - 1));

  logic          clock = 1'b0;
  logic          reset;
  logic          rv [2];
  logic [RW-1:0] rd [2];
  logic          rr [2];
  logic          av [2];
  logic [AW-1:0] ad [2];
  logic          ar [2];

  always #5 clock = ~clock;

  bandit_agent #(
    .ACTIONS(NA), .ACTION_WIDTH(AW), .REWARD_WIDTH(RW), .VALUE_WIDTH(VW),
    .ALPHA_SHIFT(0), .INIT_VALUE(0), .EPSILON(8), .SEED(16'hACE1)
  ) dut_a0 (
    .clock(clock), .reset(reset),
    .reward_valid(rv[0]), .reward_data(rd[0]), .reward_ready(rr[0]),
    .action_valid(av[0]), .action_data(ad[0]), .action_ready(ar[0])
  );

  bandit_agent #(
    .ACTIONS(NA), .ACTION_WIDTH(AW), .REWARD_WIDTH(RW), .VALUE_WIDTH(VW),
    .ALPHA_SHIFT(3), .INIT_VALUE(0), .EPSILON(8), .SEED(16'hACE1)
  ) dut_a3 (
    .clock(clock), .reset(reset),
    .reward_valid(rv[1]), .reward_data(rd[1]), .reward_ready(rr[1]),
    .action_valid(av[1]), .action_data(ad[1]), .action_ready(ar[1])
  );

  int vectors    = 0;
  int miscompares = 0;
  int q [2][NA];
  int shift_of [2] = '{0, 3};
  int last_lane;
  int elapsed;
  int exp_lat;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int greedy(input int u);
    int best = 0;
    for (int i = 1; i < NA; i++) begin
      if (q[u][i] > q[u][best]) best = i;
    end
    return best;
  endfunction

  // Q + floor((r - Q) / 2^s), clamped to the signed value range.
  function automatic int model_update(input int qv, input int r, input int s);
    int d, p, step, v;
    d = r - qv;
    p = 1 << s;
    if (d >= 0) step = d / p;
    else        step = -((-d + p - 1) / p);
    v = qv + step;
    if (v > VMAX) v = VMAX;
    if (v < VMIN) v = VMIN;
    return v;
  endfunction

  function automatic logic signed [31:0] dut_q(input int u, input int a);
    if (u == 0) return dut_a0.r_q[a];
    return dut_a3.r_q[a];
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < NA; i++) q[u][i] = 0;
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset     = 1'b1;
    last_lane = 0;
    elapsed   = 0;
    exp_lat   = NA + 1;
  endtask

  task automatic wait_action(input int u);
    int lat = elapsed;
    int budget = 0;
    while (av[u] !== 1'b1 && budget < 200) begin
      chk("rr_idle", rr[u], 0);
      @(negedge clock);
      lat++;
      budget++;
    end
    chk("action_valid", av[u], 1);
    if (last_lane == u && exp_lat > 0) chk("latency", lat, exp_lat);
  endtask

  task automatic round(input int u, input int r, input int hold, input bit pulse);
    int a;
    wait_action(u);
    a = greedy(u);
    chk("action", ad[u], a);
    chk("rr_offer", rr[u], 0);
    for (int h = 0; h < hold; h++) begin
      rv[u] = pulse && (h == 0);
      rd[u] = 8'($urandom_range(255));
      @(negedge clock);
      chk("hold_valid", av[u], 1);
      chk("hold_data", ad[u], a);
      chk("hold_rr", rr[u], 0);
    end
    rv[u] = 1'b0;
    ar[u] = 1'b1;
    @(negedge clock);
    ar[u] = 1'b0;
    chk("valid_drop", av[u], 0);
    chk("rr_rise", rr[u], 1);
    rd[u] = 8'(r);
    rv[u] = 1'b1;
    @(negedge clock);
    rv[u] = 1'b0;
    chk("rr_drop", rr[u], 0);
    q[u][a] = model_update(q[u][a], r, shift_of[u]);
    @(negedge clock);
    chk("table", dut_q(u, a), q[u][a]);
    last_lane = u;
    elapsed   = 1;
    exp_lat   = NA + 2;
  endtask

  task automatic lane_switch(input int u);
    if (last_lane != u) begin
      last_lane = u;
      exp_lat   = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rv[u] = 1'b0; rd[u] = '0; ar[u] = 1'b0;
    end
    model_reset();
    last_lane = 0; elapsed = 0; exp_lat = -1;
    repeat (3) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      chk("rst_valid", av[u], 0);
      chk("rst_data", ad[u], 0);
      chk("rst_rr", rr[u], 0);
    end
    release_reset();

    // Directed: tie-break, negative reward, saturation (lane 0, Q <- r).
    round(0, -5, 0, 1'b0);
    round(0, 7, 0, 1'b0);
    round(0, -128, 1, 1'b1);
    round(0, 127, 0, 1'b0);
    round(0, 127, 2, 1'b0);

    // Directed: slow learning toward +80 (lane 1, 10, 18, 25, ...).
    lane_switch(1);
    for (int k = 0; k < 6; k++) round(1, 80, 0, 1'b0);
    chk("converge_bound", (dut_q(1, 0) <= 80) ? 1 : 0, 1);
    round(1, 80, 20, 1'b1);

    // Randomized rounds interleaved across both lanes.
    for (int k = 0; k < 40; k++) begin
      int u;
      u = int'($urandom_range(1));
      lane_switch(u);
      round(u, int'($urandom_range(255)) - 128, int'($urandom_range(3)),
            1'($urandom_range(1)));
    end

    // Reset while lane 0 waits for its reward.
    lane_switch(0);
    wait_action(0);
    ar[0] = 1'b1;
    @(negedge clock);
    ar[0] = 1'b0;
    chk("pre_rst_rr", rr[0], 1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int u = 0; u < 2; u++) begin
      chk("async_valid", av[u], 0);
      chk("async_data", ad[u], 0);
      chk("async_rr", rr[u], 0);
      for (int i = 0; i < NA; i++) chk("async_table", dut_q(u, i), 0);
    end
    release_reset();
    for (int k = 0; k < 6; k++) begin
      round(0, int'($urandom_range(255)) - 128, int'($urandom_range(2)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bandit_agent.md
Name: bandit_agent

Overview:
Parametrised multi-armed bandit agent, the successor to bandit, with configurable action count, reward width and value width. It keeps a signed action-value table and picks the greedy action (argmax) by a sequential scan. The action is offered on a valid/ready output; the block then waits for a reward on a valid/ready input and updates the chosen entry with a shift-based learning rate. It sits between the environment model and the rest of the learning pipeline.

Parameters:
ACTIONS, 256, number of actions; power of 2, ≥2
ACTION_WIDTH, $clog2(ACTIONS), width of action index
REWARD_WIDTH, 8, signed reward width
VALUE_WIDTH, 8, signed table entry width; ≥ REWARD_WIDTH
ALPHA_SHIFT, 3, learning rate = 2^-ALPHA_SHIFT; 0..VALUE_WIDTH
INIT_VALUE, 0, signed reset value for every table entry
EPSILON, 8, exploration threshold out of 256 (optional feature only)
SEED, 16'hACE1, nonzero LFSR reset value (optional feature only)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
reward_valid  input  1  reward_data valid
reward_data  input  REWARD_WIDTH  signed reward for the last issued action
reward_ready  output  1  agent accepts reward
action_valid  output  1  action_data valid
action_data  output  ACTION_WIDTH  chosen action index
action_ready  input  1  environment accepts action

Behaviour:
- Reset (reset low, asynchronous): state=SELECT, scan index=0, best index=0, best value=entry 0 after reset, every table entry=INIT_VALUE, action_valid=0, action_data=0, reward_ready=0. Reset mid-operation aborts any pending action or reward with no table update.
- FSM states: SELECT → OFFER → WAIT_REWARD → UPDATE → SELECT.
- SELECT: scans one entry per cycle, index 0..ACTIONS-1. An entry replaces the current best only if it is strictly greater, so ties go to the lowest index. The scan takes exactly ACTIONS cycles. Then the FSM goes to OFFER with action_data=best index.
- OFFER: action_valid=1. action_data is held stable until the handshake. When action_valid && action_ready at a rising edge, action_valid drops the next cycle and the FSM goes to WAIT_REWARD. There is no timeout.
- WAIT_REWARD: reward_ready=1 (registered, high for the whole state). When reward_valid && reward_ready, reward_data is latched, reward_ready drops the next cycle, and the FSM goes to UPDATE. reward_valid outside WAIT_REWARD is ignored and not acknowledged.
- UPDATE (1 cycle): Q[a] ← sat_VALUE_WIDTH(Q[a] + ((sign_ext(r) − Q[a]) >>> ALPHA_SHIFT)).
  - Compute in VALUE_WIDTH+2 signed bits.
  - >>> is an arithmetic shift and truncates toward −inf.
  - Saturate to [−2^(VALUE_WIDTH−1), 2^(VALUE_WIDTH−1)−1].
  - ALPHA_SHIFT=0 gives Q ← r.
- Latency: from entering SELECT to action_valid is ACTIONS+1 cycles. From the reward handshake to the next action_valid is ACTIONS+2 cycles.
- The table is only written in UPDATE. The scan always sees updated values.

Optional Feature:
BANDIT_EXPLORE_EN
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11), reset to SEED, advances every clock.
  - At scan completion, if lfsr[7:0] < EPSILON, action_data = lfsr[8+ACTION_WIDTH-1:8] (bits above 15 read as 0, so this requires ACTION_WIDTH ≤ 8); otherwise the greedy index is used.
  - EPSILON=0 is pure greedy; EPSILON=256 is always random.
- Undefined: no LFSR is present, the block is purely greedy, and EPSILON and SEED are unused.

Test Plan:
- ACTIONS=4, INIT_VALUE=0; release reset → action_valid rises 5 cycles later with action_data=0 (tie → lowest index); reward_ready=0 throughout.
- ACTIONS=4, ALPHA_SHIFT=0: accept action 0, send reward −5 → next action=1 (Q[0]=−5, others 0); send +7 to action 1 → next action=1 again.
- ALPHA_SHIFT=3, VALUE_WIDTH=8: Q=0, reward +80 → Q=10; repeated +80 converges upward (10, 18, 25, …) and never exceeds 80.
- Saturation, VALUE_WIDTH=REWARD_WIDTH=8, ALPHA_SHIFT=0: reward −128 → Q=−128; reward +127 → Q=127.
- Handshake stress: hold action_ready=0 for 20 cycles → action_valid and action_data stay constant. Pulse reward_valid during OFFER → ignored, no update. Apply reset during WAIT_REWARD → all outputs reach reset values immediately, without waiting for a clock edge, and the table returns to INIT_VALUE.
- BANDIT_EXPLORE_EN, ACTIONS=256, EPSILON=256 → over 100 rounds at least 90 distinct actions are seen. With EPSILON=0 → same sequence as the non-macro build.
